// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder.
// The master side drives the operands and handshake; the slave (the adder) returns
// the registered results. When FULL_ADDER_OVF_EN is defined, the bundle also
// carries the registered signed-overflow flag.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             chain;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output a, b, cin, chain, in_valid,
        input  sum, cout, out_valid, ovf
    );

    modport slave (
        input  a, b, cin, chain, in_valid,
        output sum, cout, out_valid, ovf
    );
`else
    modport master (
        output a, b, cin, chain, in_valid,
        input  sum, cout, out_valid
    );

    modport slave (
        input  a, b, cin, chain, in_valid,
        output sum, cout, out_valid
    );
`endif
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with one cycle of latency.
// With chain=1, the registered carry-out is used as the carry-in. This lets
// wide operands be added word by word, least-significant word first, with idle
// gaps allowed between words.
// Optional feature macro: FULL_ADDER_OVF_EN adds a registered signed-overflow flag.
// WIDTH must match the WIDTH of the connected full_adder_if (legal range 1..64).
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    full_adder_if.slave   bus
);

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             out_valid_q;
    logic             carry_in;
    logic [WIDTH:0]   carry;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf_q;
    logic             ovf_d;
`endif

    // Carry source: the held carry-out continues a chained add.
    assign carry_in = bus.chain ? cout_q : bus.cin;

    // Ripple chain of 1-bit full-adder cells.
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
            carry[i + 1] = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
        end
        cout_d = carry[WIDTH];
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: both operands have the same sign and the result sign differs.
    always_comb begin
        ovf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_d[WIDTH-1] != bus.a[WIDTH-1]);
    end
`endif

    // Result registers: load on an accepted add, hold while idle, clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else if (bus.in_valid) begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= 1'b1;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;
`ifdef FULL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Testbench for full_adder. It runs a 1-bit instance and an 8-bit instance side by side.
// An arithmetic reference model is compared against both instances on every negedge.
// Directed literal checks pin down the cases worked out by hand.
module tb_full_adder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   chk_en;

    full_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_if #(.WIDTH(8)) bus8 ();

    full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    full_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer arithmetic on the sampled inputs.
    logic [7:0] e8_sum;
    logic       e8_cout, e8_valid, e8_ovf;
    logic       e1_sum, e1_cout, e1_valid, e1_ovf;

    function automatic int sval(input logic [63:0] v, input int w);
        longint x;
        x = longint'(v & ((64'd1 << w) - 1));
        if (v[w-1]) x = x - (longint'(1) << w);
        return int'(x);
    endfunction

    function automatic logic sovf(input logic [63:0] a, input logic [63:0] b, input logic c, input int w);
        int t;
        t = sval(a, w) + sval(b, w) + int'(c);
        return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
    endfunction

    always @(posedge clk) begin
        logic [8:0] t8;
        logic [1:0] t1;
        logic       c8, c1;
        if (rst) begin
            e8_sum <= '0; e8_cout <= 1'b0; e8_valid <= 1'b0; e8_ovf <= 1'b0;
            e1_sum <= '0; e1_cout <= 1'b0; e1_valid <= 1'b0; e1_ovf <= 1'b0;
        end else begin
            if (bus8.in_valid) begin
                c8 = bus8.chain ? e8_cout : bus8.cin;
                t8 = 9'(bus8.a) + 9'(bus8.b) + 9'(c8);
                e8_sum   <= t8[7:0];
                e8_cout  <= t8[8];
                e8_ovf   <= sovf(64'(bus8.a), 64'(bus8.b), c8, 8);
                e8_valid <= 1'b1;
            end else begin
                e8_valid <= 1'b0;
            end
            if (bus1.in_valid) begin
                c1 = bus1.chain ? e1_cout : bus1.cin;
                t1 = 2'(bus1.a) + 2'(bus1.b) + 2'(c1);
                e1_sum   <= t1[0];
                e1_cout  <= t1[1];
                e1_ovf   <= sovf(64'(bus1.a), 64'(bus1.b), c1, 1);
                e1_valid <= 1'b1;
            end else begin
                e1_valid <= 1'b0;
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({bus8.sum, bus8.cout, bus8.out_valid} !== {e8_sum, e8_cout, e8_valid}) begin
                errors++;
                $display("FAIL model8 t=%0t sum/cout/valid got %h/%b/%b exp %h/%b/%b",
                         $time, bus8.sum, bus8.cout, bus8.out_valid, e8_sum, e8_cout, e8_valid);
            end
            checks++;
            if ({bus1.sum, bus1.cout, bus1.out_valid} !== {e1_sum, e1_cout, e1_valid}) begin
                errors++;
                $display("FAIL model1 t=%0t sum/cout/valid got %b/%b/%b exp %b/%b/%b",
                         $time, bus1.sum, bus1.cout, bus1.out_valid, e1_sum, e1_cout, e1_valid);
            end
`ifdef FULL_ADDER_OVF_EN
            checks++;
            if ({bus8.ovf, bus1.ovf} !== {e8_ovf, e1_ovf}) begin
                errors++;
                $display("FAIL model_ovf t=%0t got %b/%b exp %b/%b", $time, bus8.ovf, bus1.ovf, e8_ovf, e1_ovf);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic chain, input logic iv);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.chain = chain; bus8.in_valid = iv;
    endtask

    task automatic drive1(input logic a, input logic b, input logic cin,
                          input logic chain, input logic iv);
        bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.chain = chain; bus1.in_valid = iv;
    endtask

    task automatic lit8(input string name, input logic [7:0] s, input logic c, input logic v);
        checks++;
        if ({bus8.sum, bus8.cout, bus8.out_valid} !== {s, c, v}) begin
            errors++;
            $display("FAIL %s got sum=%h cout=%b valid=%b exp sum=%h cout=%b valid=%b",
                     name, bus8.sum, bus8.cout, bus8.out_valid, s, c, v);
        end
    endtask

    task automatic lit1(input string name, input logic s, input logic c, input logic v);
        checks++;
        if ({bus1.sum, bus1.cout, bus1.out_valid} !== {s, c, v}) begin
            errors++;
            $display("FAIL %s got sum=%b cout=%b valid=%b exp sum=%b cout=%b valid=%b",
                     name, bus1.sum, bus1.cout, bus1.out_valid, s, c, v);
        end
    endtask

`ifdef FULL_ADDER_OVF_EN
    task automatic lit_ovf(input string name, input logic o, input logic c);
        checks++;
        if ({bus8.ovf, bus8.cout} !== {o, c}) begin
            errors++;
            $display("FAIL %s got ovf=%b cout=%b exp ovf=%b cout=%b", name, bus8.ovf, bus8.cout, o, c);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;

        // Reset overrides an accepted add on the same edge.
        rst = 1'b1;
        drive8(8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
        drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        lit8("reset8", 8'h00, 1'b0, 1'b0);
        lit1("reset1", 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        rst = 1'b0;
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Exhaustive 1-bit pattern; the first add after release shows up one cycle later.
        for (int k = 0; k < 50; k++) begin
            drive1(1'((k / 2) % 2), 1'((k / 3) % 2), 1'((k / 4) % 2), 1'b0, 1'b1);
            tick();
            if (k == 0) lit1("first_after_reset", 1'b0, 1'b0, 1'b1);
        end
        drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick(); lit1("w1_111", 1'b1, 1'b1, 1'b1);
        drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick(); lit1("w1_100", 1'b1, 1'b0, 1'b1);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Chained add, back-to-back.
        drive8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1); tick(); lit8("chain_w0", 8'h00, 1'b1, 1'b1);
        drive8(8'h00, 8'h00, 1'b0, 1'b1, 1'b1); tick(); lit8("chain_w1", 8'h01, 1'b0, 1'b1);

        // Chained add with a 3-cycle gap; chain=1 while idle must be ignored.
        drive8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1); tick(); lit8("gap_w0", 8'h00, 1'b1, 1'b1);
        for (int g = 0; g < 3; g++) begin
            drive8(8'h55, 8'hAA, 1'b1, 1'b1, 1'b0); tick(); lit8("gap_idle", 8'h00, 1'b1, 1'b0);
        end
        drive8(8'h00, 8'h00, 1'b0, 1'b1, 1'b1); tick(); lit8("gap_w1", 8'h01, 1'b0, 1'b1);

        // Boundaries and hold.
        drive8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1); tick(); lit8("all_ones", 8'hFF, 1'b1, 1'b1);
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0); tick(); lit8("all_ones_hold", 8'hFF, 1'b1, 1'b0);
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b1); tick(); lit8("zeros", 8'h00, 1'b0, 1'b1);
        drive8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0); tick(); lit8("zeros_hold", 8'h00, 1'b0, 1'b0);

`ifdef FULL_ADDER_OVF_EN
        drive8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1); tick(); lit_ovf("ovf_7f_01", 1'b1, 1'b0);
        drive8(8'h80, 8'h80, 1'b0, 1'b0, 1'b1); tick(); lit_ovf("ovf_80_80", 1'b1, 1'b1);
        drive8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1); tick(); lit_ovf("ovf_ff_01", 1'b0, 1'b1);
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0); tick(); lit_ovf("ovf_hold", 1'b0, 1'b1);
`endif

        // Reset mid-chain clears the held carry.
        drive8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1); tick(); lit8("midrst_w0", 8'h00, 1'b1, 1'b1);
        rst = 1'b1;
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0); tick(); lit8("midrst_rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        drive8(8'h10, 8'h01, 1'b0, 1'b1, 1'b1); tick(); lit8("midrst_w1", 8'h11, 1'b0, 1'b1);

        // Random traffic on both instances with occasional resets.
        for (int r = 0; r < 400; r++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) != 0));
            drive1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) != 0));
            tick();
        end
        rst = 1'b0;
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk_en = 1'b0;
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
